tvs_monitor: RTL and testbench
==============================

# tvs_monitor

Fabric-side consumer of the PolarFire temperature/voltage sensor (TVS) hard block. It drives the TVS channel enables and alarm-clear strobes, and captures each VALUE/CHANNEL/VALID sample. It keeps a per-channel running average, minimum and maximum, plus sticky alarm and stale-channel flags. Results are exposed through a single-cycle register read port for the ROC slow-control path.

## Interface
- AVG_LOG2, 2: log2 of the number of samples per channel average (1..4).
- TIMEOUT_CYCLES, 1000000: stale-watchdog window in CLK cycles.
- CLK  in  1  system clock; the TVS outputs are synchronous to it.
- RESET  in  1  synchronous, active-high reset.
- TVS_VALUE  in  16  raw sample value.
- TVS_CHANNEL  in  2  channel index: 0=1V, 1=1.8V, 2=2.5V, 3=temperature.
- TVS_VALID  in  1  sample strobe.
- TVS_ACTIVE  in  1  TVS conversion-active status.
- TVS_TEMP_HIGH, TVS_TEMP_LOW  in  1 each  hard-block threshold flags.
- TVS_ENABLE  out  4  {temp, 2.5V, 1.8V, 1V} enables, equal to CHAN_EN registered.
- TVS_TEMP_HIGH_CLEAR, TVS_TEMP_LOW_CLEAR  out  1 each  clear strobes to the hard block.
- CHAN_EN  in  4  software channel enable mask.
- STATS_CLEAR  in  1  pulse that reinitialises min/max, accumulators and average-valid bits.
- ALARM_CLEAR  in  1  pulse that clears the sticky alarms.
- ALARM  out  1  OR of the sticky high and low alarms.
- RD_REQ  in  1  read strobe.
- RD_ADDR  in  4  register address.
- RD_DATA  out  16  read data.
- RD_ACK  out  1  read data valid.

## Operation
- Input stage: all TVS inputs are registered once. A sample is taken on the rising edge of the registered TVS_VALID, so a multi-cycle high level produces exactly one sample.
- Samples on a channel whose CHAN_EN bit is 0 are ignored entirely.
- Each accepted sample does the following:
  - min = smaller of min and VALUE; max = larger of max and VALUE.
  - Adds VALUE to a (16+AVG_LOG2)-bit accumulator and increments the per-channel count.
  - When the count wraps (2^AVG_LOG2 samples): avg = acc >> AVG_LOG2 (truncating), the accumulator reloads to 0, and that channel's avg_valid bit is set.
  - Increments the 16-bit wrapping global sample count.
- Alarm FSM, one instance each for high and low. States:
  - IDLE: on a rising edge of the registered flag, set the sticky bit and go to CLR.
  - CLR: assert the clear strobe for exactly 1 cycle, then go to WAIT.
  - WAIT: return to IDLE when the flag deasserts, or after 16 cycles (timeout).
- Sticky bits clear only on ALARM_CLEAR. If a set and ALARM_CLEAR happen in the same cycle, the set wins.
- Stale watchdog:
  - A free-running counter wraps every TIMEOUT_CYCLES.
  - Each channel has a seen bit, set by any accepted sample.
  - At wrap, stale[i] = CHAN_EN[i] & ~seen[i], and all seen bits clear.
  - stale[i] is cleared by the next accepted sample on channel i.
- Register map (RD_ADDR):
  - 0-3: avg for channels 0-3.
  - 4-7: min for channels 0-3.
  - 8-11: max for channels 0-3.
  - 12: status word: [0] high sticky, [1] low sticky, [5:2] stale, [9:6] avg_valid, [10] TVS_ACTIVE, [15:11] 0.
  - 13: sample count.
  - 14-15: read 0.
- STATS_CLEAR: min=16'hFFFF, max=0, accumulators and counts 0, avg_valid 0, avg 0.
  - If a sample arrives in the same cycle, it is applied after the clear: min = max = VALUE, count = 1.

## Timing
- Reset values:
  - TVS_ENABLE=0, both clear strobes 0, ALARM=0, RD_DATA=0, RD_ACK=0.
  - min=16'hFFFF, max=0, avg=0, sample count=0.
  - Sticky, stale and seen bits 0; both FSMs in IDLE; watchdog counter 0.
- Sample latency: TVS_VALID rises at cycle N; registered at N+1; edge detected and statistics updated at N+2; visible to reads from N+3.
- Read handshake:
  - RD_REQ at cycle N gives RD_ACK=1 and RD_DATA at N+1.
  - RD_ACK is high for 1 cycle. RD_DATA holds its value until the next read.
  - Back-to-back RD_REQ every cycle is supported.
- Clear strobe: asserted 2 cycles after the raw flag rises (input register plus edge detect), width exactly 1 cycle.
- ALARM is combinational from the sticky registers, so it rises in the same cycle the sticky bit is set.
- TVS_ENABLE follows CHAN_EN with 1 cycle of latency.
- RESET mid-operation: everything returns to reset values on the next edge, and any clear strobe in flight is dropped.

## Structure
- Package tvs_monitor_pkg holds:
  - Register address constants.
  - Channel index constants.
  - Status-bit positions.
  - The alarm FSM state enum.
- Sub-module tvs_chan_stats implements per-channel avg/min/max/accumulator/avg_valid. It has sample-enable, value, STATS_CLEAR and AVG_LOG2 inputs, and is instantiated 4 times.
- The top level holds the input registers, edge detection, the two alarm FSMs, the watchdog and the read mux.

## Test plan
- Reset, then CHAN_EN=4'hF and four samples on channel 0: 100, 200, 300, 401 -> reg 0 = 250, reg 4 = 100, reg 8 = 401, status[6] = 1, reg 13 = 4.
- TVS_VALID held high for 5 cycles with value 0x1234 -> exactly one sample, reg 13 = 1.
- TVS_TEMP_HIGH rises, deasserts 3 cycles after the clear strobe -> TVS_TEMP_HIGH_CLEAR one cycle wide at +2, ALARM=1, status[0]=1 until ALARM_CLEAR; ALARM_CLEAR coincident with a new rise leaves status[0]=1.
- CHAN_EN=4'b0111, samples only on channel 0, TIMEOUT_CYCLES=100 -> after 100 cycles status[5:2] = 4'b0110; a channel-1 sample then clears stale[1].
- STATS_CLEAR in the same cycle as a sample of 500 on channel 2 -> reg 6 = reg 10 = 500, status[8] = 0.
- Back-to-back reads of addresses 0..15 -> RD_ACK high on 16 consecutive cycles, and addresses 14-15 return 0.

Source files
------------

// File: rtl/tvs_monitor_pkg.sv
// Shared constants, status layout and alarm FSM definitions for the TVS monitor.
package tvs_monitor_pkg;

    localparam logic [3:0] ADDR_AVG_BASE = 4'd0;
    localparam logic [3:0] ADDR_MIN_BASE = 4'd4;
    localparam logic [3:0] ADDR_MAX_BASE = 4'd8;
    localparam logic [3:0] ADDR_STATUS   = 4'd12;
    localparam logic [3:0] ADDR_COUNT    = 4'd13;

    localparam logic [1:0] CH_1V0  = 2'd0;
    localparam logic [1:0] CH_1V8  = 2'd1;
    localparam logic [1:0] CH_2V5  = 2'd2;
    localparam logic [1:0] CH_TEMP = 2'd3;

    localparam int STAT_HIGH          = 0;
    localparam int STAT_LOW           = 1;
    localparam int STAT_STALE_LSB     = 2;
    localparam int STAT_AVG_VALID_LSB = 6;
    localparam int STAT_ACTIVE        = 10;

    typedef enum logic [1:0] {
        ALM_IDLE = 2'd0,
        ALM_CLR  = 2'd1,
        ALM_WAIT = 2'd2
    } alarm_state_t;

    // Full alarm FSM state, kept as one struct so it can be probed as a unit.
    typedef struct packed {
        alarm_state_t state;
        logic [3:0]   wait_cnt;
    } alarm_fsm_t;

    function automatic alarm_fsm_t alarm_next(alarm_fsm_t cur, logic rise, logic flag);
        alarm_fsm_t nxt;
        nxt = cur;
        case (cur.state)
            ALM_IDLE: begin
                if (rise) nxt.state = ALM_CLR;
            end
            ALM_CLR: begin
                nxt.state    = ALM_WAIT;
                nxt.wait_cnt = 4'd0;
            end
            ALM_WAIT: begin
                if (!flag || cur.wait_cnt == 4'hF) begin
                    nxt.state    = ALM_IDLE;
                    nxt.wait_cnt = 4'd0;
                end else begin
                    nxt.wait_cnt = cur.wait_cnt + 4'd1;
                end
            end
            default: begin
                nxt.state    = ALM_IDLE;
                nxt.wait_cnt = 4'd0;
            end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/tvs_chan_stats.sv
// Per-channel running statistics: block average over 2^AVG_LOG2 samples, min and max.
module tvs_chan_stats #(
    parameter int AVG_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_en,
    input  logic [15:0] value,
    input  logic        stats_clear,
    output logic [15:0] avg,
    output logic [15:0] min_val,
    output logic [15:0] max_val,
    output logic        avg_valid
);

    localparam int ACC_W = 16 + AVG_LOG2;

    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [AVG_LOG2-1:0] cnt;

    assign acc_sum = acc + ACC_W'(value);

    always_ff @(posedge clk) begin
        if (reset) begin
            avg       <= 16'd0;
            min_val   <= 16'hFFFF;
            max_val   <= 16'd0;
            avg_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
        end else if (stats_clear) begin
            // A sample coincident with the clear is applied on top of the cleared state.
            avg       <= 16'd0;
            avg_valid <= 1'b0;
            if (sample_en) begin
                min_val <= value;
                max_val <= value;
                acc     <= ACC_W'(value);
                cnt     <= AVG_LOG2'(1);
            end else begin
                min_val <= 16'hFFFF;
                max_val <= 16'd0;
                acc     <= '0;
                cnt     <= '0;
            end
        end else if (sample_en) begin
            if (value < min_val) min_val <= value;
            if (value > max_val) max_val <= value;
            if (cnt == '1) begin
                avg       <= acc_sum[AVG_LOG2 +: 16];
                acc       <= '0;
                cnt       <= '0;
                avg_valid <= 1'b1;
            end else begin
                acc <= acc_sum;
                cnt <= cnt + AVG_LOG2'(1);
            end
        end
    end

endmodule

// File: rtl/tvs_monitor.sv
// Fabric-side TVS consumer: input capture, per-channel stats, sticky alarms,
// stale-channel watchdog and a single-cycle register read port.
module tvs_monitor
    import tvs_monitor_pkg::*;
#(
    parameter int AVG_LOG2       = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] TVS_VALUE,
    input  logic [1:0]  TVS_CHANNEL,
    input  logic        TVS_VALID,
    input  logic        TVS_ACTIVE,
    input  logic        TVS_TEMP_HIGH,
    input  logic        TVS_TEMP_LOW,
    output logic [3:0]  TVS_ENABLE,
    output logic        TVS_TEMP_HIGH_CLEAR,
    output logic        TVS_TEMP_LOW_CLEAR,
    input  logic [3:0]  CHAN_EN,
    input  logic        STATS_CLEAR,
    input  logic        ALARM_CLEAR,
    output logic        ALARM,
    input  logic        RD_REQ,
    input  logic [3:0]  RD_ADDR,
    output logic [15:0] RD_DATA,
    output logic        RD_ACK
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [15:0] value_r;
    logic [1:0]  channel_r;
    logic        valid_r, valid_d, active_r;
    logic        high_r, high_d, low_r, low_d;
    logic [3:0]  chan_en_r;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            value_r   <= 16'd0;
            channel_r <= 2'd0;
            valid_r   <= 1'b0;
            valid_d   <= 1'b0;
            active_r  <= 1'b0;
            high_r    <= 1'b0;
            high_d    <= 1'b0;
            low_r     <= 1'b0;
            low_d     <= 1'b0;
            chan_en_r <= 4'd0;
        end else begin
            value_r   <= TVS_VALUE;
            channel_r <= TVS_CHANNEL;
            valid_r   <= TVS_VALID;
            valid_d   <= valid_r;
            active_r  <= TVS_ACTIVE;
            high_r    <= TVS_TEMP_HIGH;
            high_d    <= high_r;
            low_r     <= TVS_TEMP_LOW;
            low_d     <= low_r;
            chan_en_r <= CHAN_EN;
        end
    end

    assign TVS_ENABLE = chan_en_r;

    // A held-high VALID yields one sample; disabled channels are dropped here.
    logic       accepted;
    logic [3:0] hit;

    assign accepted = valid_r & ~valid_d & chan_en_r[channel_r];

    always_comb begin
        hit = 4'd0;
        for (int i = 0; i < 4; i++) begin
            hit[i] = accepted && (channel_r == 2'(i));
        end
    end

    logic [15:0] avg   [4];
    logic [15:0] min_v [4];
    logic [15:0] max_v [4];
    logic [3:0]  avg_valid;

    for (genvar g = 0; g < 4; g++) begin : g_chan
        tvs_chan_stats #(
            .AVG_LOG2(AVG_LOG2)
        ) u_stats (
            .clk        (CLK),
            .reset      (RESET),
            .sample_en  (hit[g]),
            .value      (value_r),
            .stats_clear(STATS_CLEAR),
            .avg        (avg[g]),
            .min_val    (min_v[g]),
            .max_val    (max_v[g]),
            .avg_valid  (avg_valid[g])
        );
    end

    logic [15:0] sample_cnt;

    always_ff @(posedge CLK) begin
        if (RESET)         sample_cnt <= 16'd0;
        else if (accepted) sample_cnt <= sample_cnt + 16'd1;
    end

    alarm_fsm_t high_q, high_n, low_q, low_n;
    logic       high_rise, low_rise, high_set, low_set;
    logic       sticky_high, sticky_low;

    assign high_rise = high_r & ~high_d;
    assign low_rise  = low_r & ~low_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            high_q <= '{state: ALM_IDLE, wait_cnt: 4'd0};
            low_q  <= '{state: ALM_IDLE, wait_cnt: 4'd0};
        end else begin
            high_q <= high_n;
            low_q  <= low_n;
        end
    end

    always_comb begin
        high_n   = alarm_next(high_q, high_rise, high_r);
        low_n    = alarm_next(low_q, low_rise, low_r);
        high_set = (high_q.state == ALM_IDLE) && high_rise;
        low_set  = (low_q.state == ALM_IDLE) && low_rise;
    end

    assign TVS_TEMP_HIGH_CLEAR = (high_q.state == ALM_CLR);
    assign TVS_TEMP_LOW_CLEAR  = (low_q.state == ALM_CLR);

    // A set in the same cycle as ALARM_CLEAR wins.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sticky_high <= 1'b0;
            sticky_low  <= 1'b0;
        end else begin
            if (high_set)         sticky_high <= 1'b1;
            else if (ALARM_CLEAR) sticky_high <= 1'b0;
            if (low_set)          sticky_low  <= 1'b1;
            else if (ALARM_CLEAR) sticky_low  <= 1'b0;
        end
    end

    assign ALARM = sticky_high | sticky_low;

    logic [WD_W-1:0] wd_cnt;
    logic            wd_wrap;
    logic [3:0]      seen, stale, seen_now;

    assign wd_wrap  = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign seen_now = seen | hit;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wd_cnt <= '0;
            seen   <= 4'd0;
            stale  <= 4'd0;
        end else if (wd_wrap) begin
            wd_cnt <= '0;
            seen   <= 4'd0;
            stale  <= chan_en_r & ~seen_now;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
            seen   <= seen_now;
            stale  <= stale & ~hit;
        end
    end

    logic [15:0] status_word;
    logic [15:0] rd_mux;

    always_comb begin
        status_word                                    = 16'd0;
        status_word[STAT_HIGH]                         = sticky_high;
        status_word[STAT_LOW]                          = sticky_low;
        status_word[STAT_STALE_LSB +: 4]               = stale;
        status_word[STAT_AVG_VALID_LSB +: 4]           = avg_valid;
        status_word[STAT_ACTIVE]                       = active_r;

        rd_mux = 16'd0;
        case (RD_ADDR[3:2])
            ADDR_AVG_BASE[3:2]: rd_mux = avg[RD_ADDR[1:0]];
            ADDR_MIN_BASE[3:2]: rd_mux = min_v[RD_ADDR[1:0]];
            ADDR_MAX_BASE[3:2]: rd_mux = max_v[RD_ADDR[1:0]];
            default: begin
                if (RD_ADDR == ADDR_STATUS)     rd_mux = status_word;
                else if (RD_ADDR == ADDR_COUNT) rd_mux = sample_cnt;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            RD_DATA <= 16'd0;
            RD_ACK  <= 1'b0;
        end else begin
            RD_ACK <= RD_REQ;
            if (RD_REQ) RD_DATA <= rd_mux;
        end
    end

endmodule

// File: tb/tb_tvs_monitor.sv
// Self-checking bench for tvs_monitor: table-driven sample vectors plus
// hand-written alarm, watchdog, clear and read-burst sequences.
module tb_tvs_monitor;

    localparam int AVG_LOG2 = 2;
    localparam int TIMEOUT  = 100;

    logic        CLK;
    logic        RESET;
    logic [15:0] TVS_VALUE;
    logic [1:0]  TVS_CHANNEL;
    logic        TVS_VALID;
    logic        TVS_ACTIVE;
    logic        TVS_TEMP_HIGH;
    logic        TVS_TEMP_LOW;
    logic [3:0]  TVS_ENABLE;
    logic        TVS_TEMP_HIGH_CLEAR;
    logic        TVS_TEMP_LOW_CLEAR;
    logic [3:0]  CHAN_EN;
    logic        STATS_CLEAR;
    logic        ALARM_CLEAR;
    logic        ALARM;
    logic        RD_REQ;
    logic [3:0]  RD_ADDR;
    logic [15:0] RD_DATA;
    logic        RD_ACK;

    tvs_monitor #(
        .AVG_LOG2      (AVG_LOG2),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .TVS_VALUE          (TVS_VALUE),
        .TVS_CHANNEL        (TVS_CHANNEL),
        .TVS_VALID          (TVS_VALID),
        .TVS_ACTIVE         (TVS_ACTIVE),
        .TVS_TEMP_HIGH      (TVS_TEMP_HIGH),
        .TVS_TEMP_LOW       (TVS_TEMP_LOW),
        .TVS_ENABLE         (TVS_ENABLE),
        .TVS_TEMP_HIGH_CLEAR(TVS_TEMP_HIGH_CLEAR),
        .TVS_TEMP_LOW_CLEAR (TVS_TEMP_LOW_CLEAR),
        .CHAN_EN            (CHAN_EN),
        .STATS_CLEAR        (STATS_CLEAR),
        .ALARM_CLEAR        (ALARM_CLEAR),
        .ALARM              (ALARM),
        .RD_REQ             (RD_REQ),
        .RD_ADDR            (RD_ADDR),
        .RD_DATA            (RD_DATA),
        .RD_ACK             (RD_ACK)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish exp finish within 200us");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mask_q[$];
    logic [3:0]  addr_q[$];
    int ack_run = 0;
    int max_run = 0;
    logic [15:0] sb_exp, sb_mask;
    logic [3:0]  sb_addr;

    // Read responses are matched in order against what each read expected.
    always @(negedge CLK) begin
        if (RD_ACK) begin
            ack_run++;
            if (ack_run > max_run) max_run = ack_run;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack got data %h exp no outstanding read", RD_DATA);
            end else begin
                sb_exp  = exp_q.pop_front();
                sb_mask = mask_q.pop_front();
                sb_addr = addr_q.pop_front();
                if ((RD_DATA & sb_mask) !== (sb_exp & sb_mask)) begin
                    errors++;
                    $display("FAIL rd_addr%0d got %h exp %h (mask %h)", sb_addr, RD_DATA, sb_exp, sb_mask);
                end
            end
        end else begin
            ack_run = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        repeat (2) tick();
        RESET = 1'b0;
    endtask

    task automatic rd(input logic [3:0] addr, input logic [15:0] exp,
                      input logic [15:0] mask = 16'hFFFF);
        RD_ADDR = addr;
        RD_REQ  = 1'b1;
        exp_q.push_back(exp);
        mask_q.push_back(mask);
        addr_q.push_back(addr);
        tick();
        RD_REQ = 1'b0;
    endtask

    task automatic sample(input logic [1:0] ch, input logic [15:0] val);
        TVS_CHANNEL = ch;
        TVS_VALUE   = val;
        TVS_VALID   = 1'b1;
        tick();
        TVS_VALID = 1'b0;
        repeat (3) tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL read_drain got %0d outstanding exp 0", exp_q.size());
            exp_q.delete();
            mask_q.delete();
            addr_q.delete();
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [1:0]  chan;
        logic [15:0] value;
        logic [15:0] exp_min;
        logic [15:0] exp_max;
    } vec_t;

    vec_t vecs[7];
    logic [15:0] burst_exp[16];
    localparam logic [15:0] NO_STALE = 16'hFFC3;

    initial begin
        RESET = 1'b0; TVS_VALUE = 16'd0; TVS_CHANNEL = 2'd0; TVS_VALID = 1'b0;
        TVS_ACTIVE = 1'b0; TVS_TEMP_HIGH = 1'b0; TVS_TEMP_LOW = 1'b0;
        CHAN_EN = 4'd0; STATS_CLEAR = 1'b0; ALARM_CLEAR = 1'b0;
        RD_REQ = 1'b0; RD_ADDR = 4'd0;

        vecs[0] = '{2'd0, 16'd100,   16'd100,  16'd100};
        vecs[1] = '{2'd0, 16'd200,   16'd100,  16'd200};
        vecs[2] = '{2'd0, 16'd300,   16'd100,  16'd300};
        vecs[3] = '{2'd0, 16'd401,   16'd100,  16'd401};
        vecs[4] = '{2'd3, 16'd5000,  16'd5000, 16'd5000};
        vecs[5] = '{2'd3, 16'd7,     16'd7,    16'd5000};
        vecs[6] = '{2'd3, 16'd65535, 16'd7,    16'd65535};

        // ---- reset state ----
        do_reset();
        check("rst_enable",   {12'd0, TVS_ENABLE}, 16'd0);
        check("rst_high_clr", {15'd0, TVS_TEMP_HIGH_CLEAR}, 16'd0);
        check("rst_low_clr",  {15'd0, TVS_TEMP_LOW_CLEAR}, 16'd0);
        check("rst_alarm",    {15'd0, ALARM}, 16'd0);
        check("rst_rd_data",  RD_DATA, 16'd0);
        check("rst_rd_ack",   {15'd0, RD_ACK}, 16'd0);
        rd(4'd0, 16'd0);
        rd(4'd4, 16'hFFFF);
        rd(4'd8, 16'd0);
        rd(4'd13, 16'd0);
        rd(4'd12, 16'd0);
        drain();

        // ---- enable latency and table-driven samples ----
        CHAN_EN = 4'hF;
        check("enable_before_edge", {12'd0, TVS_ENABLE}, 16'd0);
        tick();
        check("enable_after_edge", {12'd0, TVS_ENABLE}, 16'h000F);
        for (int i = 0; i < 7; i++) begin
            sample(vecs[i].chan, vecs[i].value);
            rd(ADDR_MIN(vecs[i].chan), vecs[i].exp_min);
            rd(ADDR_MAX(vecs[i].chan), vecs[i].exp_max);
            repeat ($urandom_range(0, 3)) tick();
        end
        rd(4'd0, 16'd250);
        rd(4'd3, 16'd0);
        rd(4'd12, 16'h0040, NO_STALE);
        rd(4'd13, 16'd7);
        drain();

        // ---- VALID held high for several cycles counts once ----
        do_reset();
        tick();
        TVS_CHANNEL = 2'd1;
        TVS_VALUE   = 16'h1234;
        TVS_VALID   = 1'b1;
        repeat (5) tick();
        TVS_VALID = 1'b0;
        repeat (3) tick();
        rd(4'd13, 16'd1);
        rd(4'd5, 16'h1234);
        rd(4'd9, 16'h1234);
        drain();

        // ---- back-to-back reads of every address ----
        TVS_ACTIVE = 1'b1;
        repeat (3) tick();
        burst_exp = '{16'd0, 16'd0, 16'd0, 16'd0,
                      16'hFFFF, 16'h1234, 16'hFFFF, 16'hFFFF,
                      16'd0, 16'h1234, 16'd0, 16'd0,
                      16'h0400, 16'd1, 16'd0, 16'd0};
        max_run = 0;
        for (int a = 0; a < 16; a++) begin
            RD_ADDR = 4'(a);
            RD_REQ  = 1'b1;
            exp_q.push_back(burst_exp[a]);
            mask_q.push_back((a == 12) ? NO_STALE : 16'hFFFF);
            addr_q.push_back(4'(a));
            tick();
        end
        RD_REQ = 1'b0;
        drain();
        check("burst_ack_run", 16'(max_run), 16'd16);
        TVS_ACTIVE = 1'b0;
        repeat (2) tick();

        // ---- high alarm: clear strobe timing and sticky behaviour ----
        TVS_TEMP_HIGH = 1'b1;
        tick();
        check("high_clr_plus1", {15'd0, TVS_TEMP_HIGH_CLEAR}, 16'd0);
        check("alarm_plus1",    {15'd0, ALARM}, 16'd0);
        tick();
        check("high_clr_plus2", {15'd0, TVS_TEMP_HIGH_CLEAR}, 16'd1);
        check("alarm_plus2",    {15'd0, ALARM}, 16'd1);
        tick();
        check("high_clr_plus3", {15'd0, TVS_TEMP_HIGH_CLEAR}, 16'd0);
        check("low_clr_idle",   {15'd0, TVS_TEMP_LOW_CLEAR}, 16'd0);
        repeat (2) tick();
        TVS_TEMP_HIGH = 1'b0;
        repeat (4) tick();
        check("high_clr_no_repeat", {15'd0, TVS_TEMP_HIGH_CLEAR}, 16'd0);
        rd(4'd12, 16'h0001, NO_STALE);
        check("alarm_sticky", {15'd0, ALARM}, 16'd1);
        ALARM_CLEAR = 1'b1;
        tick();
        ALARM_CLEAR = 1'b0;
        check("alarm_cleared", {15'd0, ALARM}, 16'd0);
        repeat (2) tick();

        // ALARM_CLEAR in the same cycle the new rise is detected
        TVS_TEMP_HIGH = 1'b1;
        tick();
        ALARM_CLEAR = 1'b1;
        tick();
        ALARM_CLEAR = 1'b0;
        check("set_wins_alarm", {15'd0, ALARM}, 16'd1);
        rd(4'd12, 16'h0001, NO_STALE);
        TVS_TEMP_HIGH = 1'b0;
        repeat (3) tick();

        // ---- low alarm ----
        TVS_TEMP_LOW = 1'b1;
        repeat (2) tick();
        check("low_clr_plus2", {15'd0, TVS_TEMP_LOW_CLEAR}, 16'd1);
        tick();
        check("low_clr_plus3", {15'd0, TVS_TEMP_LOW_CLEAR}, 16'd0);
        TVS_TEMP_LOW = 1'b0;
        repeat (3) tick();
        rd(4'd12, 16'h0003, NO_STALE);
        ALARM_CLEAR = 1'b1;
        tick();
        ALARM_CLEAR = 1'b0;
        check("alarm_both_cleared", {15'd0, ALARM}, 16'd0);
        drain();

        // ---- stale watchdog (channel 3 disabled, only channel 0 sampled) ----
        CHAN_EN = 4'b0111;
        do_reset();
        sample(2'd0, 16'h0042);
        repeat (40) tick();
        rd(4'd12, 16'h0000);
        repeat (60) tick();
        rd(4'd12, 16'h0018);
        sample(2'd1, 16'h0077);
        rd(4'd12, 16'h0010);
        drain();

        // ---- STATS_CLEAR coincident with a sample ----
        sample(2'd2, 16'd10);
        sample(2'd2, 16'd9000);
        sample(2'd2, 16'd20);
        sample(2'd2, 16'd30);
        rd(4'd2, 16'd2265);
        rd(4'd12, 16'h0100, NO_STALE);
        TVS_CHANNEL = 2'd2;
        TVS_VALUE   = 16'd500;
        TVS_VALID   = 1'b1;
        tick();
        TVS_VALID   = 1'b0;
        STATS_CLEAR = 1'b1;
        tick();
        STATS_CLEAR = 1'b0;
        repeat (2) tick();
        rd(4'd6, 16'd500);
        rd(4'd10, 16'd500);
        rd(4'd2, 16'd0);
        rd(4'd4, 16'hFFFF);
        rd(4'd12, 16'h0000, NO_STALE);
        sample(2'd2, 16'd600);
        sample(2'd2, 16'd700);
        sample(2'd2, 16'd800);
        rd(4'd2, 16'd650);
        rd(4'd6, 16'd500);
        rd(4'd10, 16'd800);
        rd(4'd12, 16'h0100, NO_STALE);
        drain();

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic [3:0] ADDR_MIN(input logic [1:0] ch);
        return 4'd4 + {2'd0, ch};
    endfunction

    function automatic logic [3:0] ADDR_MAX(input logic [1:0] ch);
        return 4'd8 + {2'd0, ch};
    endfunction

endmodule
